// File: rtl/arith_unit_serial_if.sv
// Operand/result bus of the digit-serial arithmetic unit.
// The master drives the request and operands; the slave returns the result and flags.
interface arith_unit_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       S;
  logic             Cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Cout;
  logic             Z;
  logic             N;
  logic             V;

  modport master (
    output start, S, Cin, A, B,
    input  ready, done, D, Cout, Z, N, V
  );

  modport slave (
    input  start, S, Cin, A, B,
    output ready, done, D, Cout, Z, N, V
  );
endinterface

// File: rtl/arith_unit_serial.sv
// Digit-serial four-mode adder: CHUNK bits per clock through one shared adder slice.
// Result and flags are held from the done pulse until the next operation completes.
module arith_unit_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  arith_unit_serial_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       s_q, s_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;

  logic [WIDTH-1:0] x_op, y_op, merged;
  logic [CHUNK-1:0] x_slice, y_slice;
  logic [CHUNK:0]   sum;
  logic             c_msb;
  int unsigned      shamt;

  // Operand select on the latched copies
  always_comb begin
    x_op = a_q;
    y_op = b_q;
    case (s_q)
      2'b00:   begin x_op = a_q;  y_op = b_q;  end
      2'b01:   begin x_op = a_q;  y_op = ~b_q; end
      2'b10:   begin x_op = ~a_q; y_op = b_q;  end
      default: begin x_op = '0;   y_op = ~b_q; end
    endcase
  end

  // Shared CHUNK-bit adder slice for the chunk selected by k
  always_comb begin
    shamt   = 32'(k_q) * CHUNK;
    x_slice = CHUNK'(x_op >> shamt);
    y_slice = CHUNK'(y_op >> shamt);
    sum     = (CHUNK+1)'(x_slice) + (CHUNK+1)'(y_slice) + (CHUNK+1)'(carry_q);
    // carry into the slice's top bit recovered from its sum bit
    c_msb   = sum[CHUNK-1] ^ x_slice[CHUNK-1] ^ y_slice[CHUNK-1];
    merged  = (res_q & ~(WIDTH'({CHUNK{1'b1}}) << shamt))
            | (WIDTH'(sum[CHUNK-1:0]) << shamt);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    k_d     = k_q;
    res_d   = res_q;
    d_d     = d_q;
    cout_d  = cout_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          s_d     = bus.S;
          carry_d = bus.Cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = merged;
        carry_d = sum[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NCHUNK - 1)) begin
          k_d     = '0;
          d_d     = merged;
          cout_d  = sum[CHUNK];
          z_d     = (merged == '0);
          n_d     = merged[WIDTH-1];
          v_d     = c_msb ^ sum[CHUNK];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      res_q   <= res_d;
      d_q     <= d_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.D     = d_q;
  assign bus.Cout  = cout_q;
  assign bus.Z     = z_q;
  assign bus.N     = n_q;
  assign bus.V     = v_q;

endmodule

// File: tb/tb_arith_unit_serial.sv
// Bench for arith_unit_serial: directed ops on an 8/2 instance plus a random sweep
// across four width/chunk configurations checked against a whole-word reference model.
module tb_arith_unit_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        cout;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  exp_t q_main[$];
  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];
  exp_t q16[$];

  arith_unit_serial_if #(.WIDTH(8))  m_if ();
  arith_unit_serial_if #(.WIDTH(8))  s1_if ();
  arith_unit_serial_if #(.WIDTH(8))  s4_if ();
  arith_unit_serial_if #(.WIDTH(8))  s8_if ();
  arith_unit_serial_if #(.WIDTH(16)) s16_if ();

  arith_unit_serial #(.WIDTH(8),  .CHUNK(2)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  arith_unit_serial #(.WIDTH(8),  .CHUNK(1)) u_c1   (.clk(clk), .rst_n(rst_n), .bus(s1_if.slave));
  arith_unit_serial #(.WIDTH(8),  .CHUNK(4)) u_c4   (.clk(clk), .rst_n(rst_n), .bus(s4_if.slave));
  arith_unit_serial #(.WIDTH(8),  .CHUNK(8)) u_c8   (.clk(clk), .rst_n(rst_n), .bus(s8_if.slave));
  arith_unit_serial #(.WIDTH(16), .CHUNK(4)) u_w16  (.clk(clk), .rst_n(rst_n), .bus(s16_if.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: {Cout,D} = X + Y + Cin, V from the carry into the top bit
  function automatic exp_t model(input int unsigned w, input logic [1:0] s, input logic cin,
                                 input logic [15:0] a, input logic [15:0] b);
    logic [31:0] mask, x, y, sum, low;
    exp_t e;
    mask = (32'd1 << w) - 32'd1;
    case (s)
      2'b00:   begin x = {16'h0, a};         y = {16'h0, b};         end
      2'b01:   begin x = {16'h0, a};         y = ~{16'h0, b} & mask; end
      2'b10:   begin x = ~{16'h0, a} & mask; y = {16'h0, b};         end
      default: begin x = 32'h0;              y = ~{16'h0, b} & mask; end
    endcase
    x     = x & mask;
    y     = y & mask;
    sum   = x + y + 32'(cin);
    low   = (x & (mask >> 1)) + (y & (mask >> 1)) + 32'(cin);
    e.d    = 16'(sum & mask);
    e.cout = sum[w];
    e.z    = ((sum & mask) == 32'h0);
    e.n    = sum[w-1];
    e.v    = low[w-1] ^ sum[w];
    return e;
  endfunction

  task automatic check_res(input string tag, input exp_t e, input logic [15:0] d,
                           input logic cout, input logic z, input logic n, input logic v);
    check({tag, "_D"},    32'(d),    32'(e.d));
    check({tag, "_Cout"}, 32'(cout), 32'(e.cout));
    check({tag, "_Z"},    32'(z),    32'(e.z));
    check({tag, "_N"},    32'(n),    32'(e.n));
    check({tag, "_V"},    32'(v),    32'(e.v));
  endtask

  task automatic main_result(input string tag);
    exp_t e;
    e = q_main.pop_front();
    check_res(tag, e, 16'(m_if.D), m_if.Cout, m_if.Z, m_if.N, m_if.V);
  endtask

  task automatic main_op(input string tag, input logic [1:0] s, input logic cin,
                         input logic [7:0] a, input logic [7:0] b);
    int cyc;
    m_if.start = 1'b1;
    m_if.S     = s;
    m_if.Cin   = cin;
    m_if.A     = a;
    m_if.B     = b;
    check({tag, "_ready_before"}, 32'(m_if.ready), 32'd1);
    step();
    q_main.push_back(model(8, s, cin, {8'h0, a}, {8'h0, b}));
    m_if.start = 1'b0;
    cyc = 1;
    while (!m_if.done && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd5);
    main_result(tag);
    step();
    check({tag, "_ready_after"}, 32'(m_if.ready), 32'd1);
    check({tag, "_done_cleared"}, 32'(m_if.done), 32'd0);
  endtask

  initial begin
    int cyc;
    int gap;
    int lat[4];
    exp_t e;
    logic [1:0]  rs;
    logic        rc;
    logic [15:0] ra, rb;

    m_if.start = 1'b0;  m_if.S = '0;  m_if.Cin = 1'b0;  m_if.A = '0;  m_if.B = '0;
    s1_if.start = 1'b0; s1_if.S = '0; s1_if.Cin = 1'b0; s1_if.A = '0; s1_if.B = '0;
    s4_if.start = 1'b0; s4_if.S = '0; s4_if.Cin = 1'b0; s4_if.A = '0; s4_if.B = '0;
    s8_if.start = 1'b0; s8_if.S = '0; s8_if.Cin = 1'b0; s8_if.A = '0; s8_if.B = '0;
    s16_if.start = 1'b0; s16_if.S = '0; s16_if.Cin = 1'b0; s16_if.A = '0; s16_if.B = '0;

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_ready", 32'(m_if.ready), 32'd1);
    check("rst_done",  32'(m_if.done),  32'd0);
    check("rst_D",     32'(m_if.D),     32'h00);
    check("rst_Cout",  32'(m_if.Cout),  32'd0);
    check("rst_Z",     32'(m_if.Z),     32'd1);
    check("rst_N",     32'(m_if.N),     32'd0);
    check("rst_V",     32'(m_if.V),     32'd0);

    main_op("add",       2'b00, 1'b0, 8'h3C, 8'h5A);
    main_op("a_minus_b", 2'b01, 1'b1, 8'h10, 8'h10);
    main_op("b_minus_a", 2'b10, 1'b1, 8'h05, 8'h03);
    main_op("neg_zero",  2'b11, 1'b1, 8'h00, 8'h00);
    main_op("neg_one",   2'b11, 1'b1, 8'h00, 8'h01);
    main_op("overflow",  2'b00, 1'b0, 8'h7F, 8'h01);

    // start pulses and operand changes during RUN must be ignored
    m_if.start = 1'b1; m_if.S = 2'b00; m_if.Cin = 1'b0; m_if.A = 8'h01; m_if.B = 8'h02;
    step();
    q_main.push_back(model(8, 2'b00, 1'b0, 16'h0001, 16'h0002));
    cyc = 1;
    for (int i = 0; i < 3; i++) begin
      m_if.start = 1'b1;
      m_if.A = 8'($urandom);
      m_if.B = 8'($urandom);
      m_if.S = 2'($urandom);
      check("busy_ready_low", 32'(m_if.ready), 32'd0);
      check("busy_no_done",   32'(m_if.done),  32'd0);
      step();
      cyc++;
    end
    m_if.start = 1'b0;
    while (!m_if.done && cyc < 20) begin
      step();
      cyc++;
    end
    check("busy_latency", 32'(cyc), 32'd5);
    main_result("busy");
    step();
    check("busy_ready_after", 32'(m_if.ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("busy_no_extra_done", 32'(m_if.done), 32'd0);
      step();
    end

    // reset while in RUN with k=2
    m_if.start = 1'b1; m_if.S = 2'b00; m_if.Cin = 1'b0; m_if.A = 8'h20; m_if.B = 8'h11;
    step();
    m_if.start = 1'b0;
    step();
    step();
    check("midrst_ready_low", 32'(m_if.ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_ready", 32'(m_if.ready), 32'd1);
    check("midrst_D",     32'(m_if.D),     32'h00);
    check("midrst_Z",     32'(m_if.Z),     32'd1);
    check("midrst_done",  32'(m_if.done),  32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_done", 32'(m_if.done), 32'd0);
    end
    main_op("post_reset", 2'b00, 1'b1, 8'h20, 8'h11);

    // start held high: back-to-back accepts every NCHUNK+2 cycles
    m_if.start = 1'b1; m_if.S = 2'b01; m_if.Cin = 1'b1; m_if.A = 8'h44; m_if.B = 8'h22;
    step();
    q_main.push_back(model(8, 2'b01, 1'b1, 16'h0044, 16'h0022));
    q_main.push_back(model(8, 2'b01, 1'b1, 16'h0044, 16'h0022));
    cyc = 1;
    while (!m_if.done && cyc < 20) begin
      step();
      cyc++;
    end
    check("held_latency", 32'(cyc), 32'd5);
    main_result("held_first");
    gap = 0;
    do begin
      step();
      gap++;
    end while (!m_if.done && gap < 20);
    m_if.start = 1'b0;
    check("held_period", 32'(gap), 32'd6);
    main_result("held_second");
    step();
    step();
    check("held_idle_ready", 32'(m_if.ready), 32'd1);

    // random sweep over CHUNK=1/4/8 at WIDTH=8 and WIDTH=16/CHUNK=4
    for (int op = 0; op < 1000; op++) begin
      rs = 2'($urandom);
      rc = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      s1_if.start = 1'b1;  s1_if.S = rs;  s1_if.Cin = rc;  s1_if.A = ra[7:0];  s1_if.B = rb[7:0];
      s4_if.start = 1'b1;  s4_if.S = rs;  s4_if.Cin = rc;  s4_if.A = ra[7:0];  s4_if.B = rb[7:0];
      s8_if.start = 1'b1;  s8_if.S = rs;  s8_if.Cin = rc;  s8_if.A = ra[7:0];  s8_if.B = rb[7:0];
      s16_if.start = 1'b1; s16_if.S = rs; s16_if.Cin = rc; s16_if.A = ra;      s16_if.B = rb;
      step();
      q1.push_back(model(8, rs, rc, {8'h0, ra[7:0]}, {8'h0, rb[7:0]}));
      q4.push_back(model(8, rs, rc, {8'h0, ra[7:0]}, {8'h0, rb[7:0]}));
      q8.push_back(model(8, rs, rc, {8'h0, ra[7:0]}, {8'h0, rb[7:0]}));
      q16.push_back(model(16, rs, rc, ra, rb));
      s1_if.start = 1'b0; s4_if.start = 1'b0; s8_if.start = 1'b0; s16_if.start = 1'b0;
      lat = '{0, 0, 0, 0};
      for (int c = 1; c <= 12; c++) begin
        if (s1_if.done && lat[0] == 0) begin
          lat[0] = c;
          e = q1.pop_front();
          check_res("c1", e, 16'(s1_if.D), s1_if.Cout, s1_if.Z, s1_if.N, s1_if.V);
        end
        if (s4_if.done && lat[1] == 0) begin
          lat[1] = c;
          e = q4.pop_front();
          check_res("c4", e, 16'(s4_if.D), s4_if.Cout, s4_if.Z, s4_if.N, s4_if.V);
        end
        if (s8_if.done && lat[2] == 0) begin
          lat[2] = c;
          e = q8.pop_front();
          check_res("c8", e, 16'(s8_if.D), s8_if.Cout, s8_if.Z, s8_if.N, s8_if.V);
        end
        if (s16_if.done && lat[3] == 0) begin
          lat[3] = c;
          e = q16.pop_front();
          check_res("w16c4", e, s16_if.D, s16_if.Cout, s16_if.Z, s16_if.N, s16_if.V);
        end
        step();
      end
      check("c1_latency",    32'(lat[0]), 32'd9);
      check("c4_latency",    32'(lat[1]), 32'd3);
      check("c8_latency",    32'(lat[2]), 32'd2);
      check("w16c4_latency", 32'(lat[3]), 32'd5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
